alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have no parameters; all widths fixed: operands 32 bits, wide result 64 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op  input  3  operation: op[1:0] kind (0 ADD, 1 AND, 2 OR, 3 XOR); op[2] invert flag.
REQ-005 floating  input  1  0 integer mode; 1 reserved (floating point not implemented).
REQ-006 form  input  1  0 dual-lane two-operand; 1 wide three-operand.
REQ-007 precision  input  2  element width: 0 8b, 1 16b, 2 32b, 3 64b.
REQ-008 A, B, C, D  input  32 each  operands.
REQ-009 Y1, Y2  output  32 each  results; {Y1,Y2} forms the 64-bit wide result, Y1 high word.

Function
REQ-010 SHALL sample all inputs on each rising clk edge and present the result on Y1/Y2 after that edge (latency 1 cycle, one new result per cycle, no handshake).
REQ-011 Narrow operand x at precision p SHALL be the low 8/16/32 bits of x sign-extended to the working width.
REQ-012 form=0, precision 0..2: Y1 = f(A,B), Y2 = f(C,D), each computed on narrowed operands, result truncated to element width then sign-extended to 32 bits.
REQ-013 form=0, precision 3: {Y1,Y2} = f({A,B},{C,D}) in 64 bits.
REQ-014 form=1, precision 0..2: {Y1,Y2} = f(A,B,C) in 64 bits on operands narrowed then sign-extended to 64; D ignored.
REQ-015 form=1, precision 3: {Y1,Y2} = f({A,B},{C,D}) in 64 bits (same as REQ-013).
REQ-016 op[2]=0: ADD sums all operands; AND/OR/XOR reduce all operands bitwise.
REQ-017 op[2]=1: every operand after the first is negated (ADD becomes SUB: first minus rest) or bitwise complemented for AND/OR/XOR (e.g. op=5 gives A & ~B & ~C).
REQ-018 Arithmetic SHALL be two's complement modulo the result width; overflow wraps silently, no flags.
REQ-019 floating=1 SHALL register Y1=Y2=0 regardless of other inputs.
REQ-020 Input changes between edges SHALL NOT affect outputs until the next rising edge.

Reset
REQ-021 rst_n low SHALL immediately (asynchronously) force Y1=0, Y2=0.
REQ-022 While rst_n low, edges SHALL be ignored; the first rising edge after release registers the current inputs.
REQ-023 Reset asserted mid-stream SHALL discard the pending result; no state beyond the output registers exists.

Structure
REQ-024 Shared package alu_pkg SHALL hold op-kind constants (ADD/AND/OR/XOR, INV bit), precision constants (P8/P16/P32/P64) and form constants.
REQ-025 One sub-module alu_lane SHALL compute one two-operand function on 64-bit sign-extended operands; alu instantiates two lanes (form 0 low lanes) and chains them for three-operand form 1.
REQ-026 Output registers and result muxing SHALL live in alu top level; the lanes are purely combinational.

Verification
REQ-027 form=1, precision=2, floating=0, op=0, A=1,B=2,C=3,D=2 -> after one edge {Y1,Y2}=6.
REQ-028 Same operands, op=4 -> {Y1,Y2}=-4 (0xFFFFFFFF_FFFFFFFC).
REQ-029 form=0, precision=0, op=0, A=0x7F,B=1,C=0xFF,D=0xFF -> Y1=0xFFFFFF80, Y2=0xFFFFFFFE.
REQ-030 form=0, precision=3, op=0, A=0,B=0xFFFFFFFF,C=0,D=1 -> Y1=1, Y2=0 (carry across words).
REQ-031 form=1, precision=2, op=5, A=0xFF,B=0x0F,C=0x30 -> {Y1,Y2}=0x00000000_000000C0; floating=1 next cycle -> 0.
REQ-032 Drive non-zero result, assert rst_n low between edges -> Y1=Y2=0 immediately, held until first edge after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-kind, precision and form encodings plus element
// narrowing helpers used by the top level.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_AND = 2'd1,
      OP_OR  = 2'd2,
      OP_XOR = 2'd3
   } op_kind_e;

   localparam int unsigned OP_INV_BIT = 2;

   localparam logic [1:0] P8  = 2'd0;
   localparam logic [1:0] P16 = 2'd1;
   localparam logic [1:0] P32 = 2'd2;
   localparam logic [1:0] P64 = 2'd3;

   localparam logic FORM_DUAL = 1'b0;
   localparam logic FORM_WIDE = 1'b1;

   // Keep the low element bits of x and sign-extend them to 32 bits.
   function automatic logic [31:0] trunc_elem(input logic [31:0] x, input logic [1:0] p);
      logic [31:0] r;
      case (p)
         P8:      r = {{24{x[7]}}, x[7:0]};
         P16:     r = {{16{x[15]}}, x[15:0]};
         P32:     r = x;
         default: r = x;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] sext_elem(input logic [31:0] x, input logic [1:0] p);
      logic [31:0] t;
      t = trunc_elem(x, p);
      return {{32{t[31]}}, t};
   endfunction

endpackage

// File: rtl/alu_lane.sv
// One combinational two-operand lane on 64-bit operands; with inv_i set the
// second operand is negated (ADD) or complemented (bitwise kinds).
module alu_lane
   import alu_pkg::*;
(
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   input  op_kind_e    kind_i,
   input  logic        inv_i,
   output logic [63:0] y_o
);

   logic [63:0] b_eff_s;

   // Condition the second operand for the inverted variants.
   always_comb begin
      b_eff_s = b_i;
      if (inv_i) begin
         if (kind_i == OP_ADD) begin
            b_eff_s = 64'd0 - b_i;
         end else begin
            b_eff_s = ~b_i;
         end
      end else begin
         b_eff_s = b_i;
      end
   end

   // Apply the selected kind.
   always_comb begin
      y_o = 64'd0;
      case (kind_i)
         OP_ADD:  y_o = a_i + b_eff_s;
         OP_AND:  y_o = a_i & b_eff_s;
         OP_OR:   y_o = a_i | b_eff_s;
         OP_XOR:  y_o = a_i ^ b_eff_s;
         default: y_o = 64'd0;
      endcase
   end

endmodule

// File: rtl/alu.sv
// Dual-lane / wide three-operand integer ALU with one cycle of latency.
// Lane 1 either runs an independent element pair or extends lane 0 with C.
module alu
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  op,
   input  logic        floating,
   input  logic        form,
   input  logic [1:0]  precision,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [31:0] C,
   input  logic [31:0] D,
   output logic [31:0] Y1,
   output logic [31:0] Y2
);

   op_kind_e    kind_s;
   logic        inv_s;
   logic [63:0] l0_a_s;
   logic [63:0] l0_b_s;
   logic [63:0] l0_y_s;
   logic [63:0] l1_a_s;
   logic [63:0] l1_b_s;
   logic [63:0] l1_y_s;
   logic [31:0] y1_d;
   logic [31:0] y2_d;
   logic [31:0] y1_q;
   logic [31:0] y2_q;

   assign kind_s = op_kind_e'(op[1:0]);
   assign inv_s  = op[OP_INV_BIT];

   // Lane 0: full 64-bit pairs at P64, otherwise narrowed A and B.
   always_comb begin
      l0_a_s = 64'd0;
      l0_b_s = 64'd0;
      if (precision == P64) begin
         l0_a_s = {A, B};
         l0_b_s = {C, D};
      end else begin
         l0_a_s = sext_elem(A, precision);
         l0_b_s = sext_elem(B, precision);
      end
   end

   // Lane 1: chained onto lane 0 in wide form, else the C/D pair.
   always_comb begin
      l1_a_s = 64'd0;
      l1_b_s = 64'd0;
      if (form == FORM_WIDE) begin
         l1_a_s = l0_y_s;
         l1_b_s = sext_elem(C, precision);
      end else begin
         l1_a_s = sext_elem(C, precision);
         l1_b_s = sext_elem(D, precision);
      end
   end

   alu_lane u_lane0 (
      .a_i    (l0_a_s),
      .b_i    (l0_b_s),
      .kind_i (kind_s),
      .inv_i  (inv_s),
      .y_o    (l0_y_s)
   );

   alu_lane u_lane1 (
      .a_i    (l1_a_s),
      .b_i    (l1_b_s),
      .kind_i (kind_s),
      .inv_i  (inv_s),
      .y_o    (l1_y_s)
   );

   // Result selection; the P64 check comes first because it overrides form.
   always_comb begin
      y1_d = 32'd0;
      y2_d = 32'd0;
      if (floating) begin
         y1_d = 32'd0;
         y2_d = 32'd0;
      end else if (precision == P64) begin
         {y1_d, y2_d} = l0_y_s;
      end else if (form == FORM_WIDE) begin
         {y1_d, y2_d} = l1_y_s;
      end else begin
         y1_d = trunc_elem(l0_y_s[31:0], precision);
         y2_d = trunc_elem(l1_y_s[31:0], precision);
      end
   end

   // Output registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y1_q <= 32'd0;
         y2_q <= 32'd0;
      end else begin
         y1_q <= y1_d;
         y2_q <= y2_d;
      end
   end

   assign Y1 = y1_q;
   assign Y2 = y2_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset behaviour, input
// stability between edges and randomized traffic against an arithmetic model.
module tb_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  op;
   logic        floating;
   logic        form;
   logic [1:0]  precision;
   logic [31:0] A, B, C, D;
   logic [31:0] Y1, Y2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (op),
      .floating  (floating),
      .form      (form),
      .precision (precision),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .Y1        (Y1),
      .Y2        (Y2)
   );

   // Low (8 << p) bits of x as a signed 64-bit number (p < 3).
   function automatic longint nar(input logic [31:0] x, input logic [1:0] p);
      longint v;
      int     sh;
      sh = 64 - (8 << p);
      v  = longint'({32'h0, x});
      v  = v <<< sh;
      v  = v >>> sh;
      return v;
   endfunction

   // Fold one more operand into an accumulator following the op rules.
   function automatic longint fold(input logic [2:0] o, input longint acc, input longint v);
      longint w;
      w = v;
      if (o[2]) w = (o[1:0] == 2'd0) ? -v : ~v;
      case (o[1:0])
         2'd0:    return acc + w;
         2'd1:    return acc & w;
         2'd2:    return acc | w;
         default: return acc ^ w;
      endcase
   endfunction

   function automatic logic [63:0] model(input logic [2:0] o, input logic fl, input logic fm,
                                         input logic [1:0] p, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
      longint      r0, r1, n;
      logic [63:0] res;
      logic [63:0] ab, cd;
      ab = {a, b};
      cd = {c, d};
      if (fl) return 64'd0;
      if (p == 2'd3) begin
         r0 = fold(o, longint'(ab), longint'(cd));
         return r0;
      end
      if (fm) begin
         r0 = fold(o, nar(a, p), nar(b, p));
         r0 = fold(o, r0, nar(c, p));
         return r0;
      end
      r0 = fold(o, nar(a, p), nar(b, p));
      r1 = fold(o, nar(c, p), nar(d, p));
      n  = nar(r0[31:0], p);
      res[63:32] = n[31:0];
      n  = nar(r1[31:0], p);
      res[31:0] = n[31:0];
      return res;
   endfunction

   task automatic drive(input logic [2:0] o, input logic fl, input logic fm, input logic [1:0] p,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] d);
      op = o; floating = fl; form = fm; precision = p;
      A = a; B = b; C = c; D = d;
   endtask

   task automatic test_reset();
      drive(3'd0, 1'b0, 1'b1, 2'd2, 32'd11, 32'd22, 32'd33, 32'd44);
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({Y1, Y2} !== 64'd0) begin
         bad++;
         $display("FAIL reset_hold got=%h want=%h", {Y1, Y2}, 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({Y1, Y2} !== 64'd66) begin
         bad++;
         $display("FAIL reset_first_edge got=%h want=%h", {Y1, Y2}, 64'd66);
      end
   endtask

   task automatic test_directed();
      logic [2:0]  t_op [6] = '{3'd0, 3'd4, 3'd0, 3'd0, 3'd5, 3'd5};
      logic        t_fl [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic        t_fm [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [1:0]  t_p  [6] = '{2'd2, 2'd2, 2'd0, 2'd3, 2'd2, 2'd2};
      logic [31:0] t_a  [6] = '{32'd1, 32'd1, 32'h7F, 32'h0, 32'hFF, 32'hFF};
      logic [31:0] t_b  [6] = '{32'd2, 32'd2, 32'h1, 32'hFFFFFFFF, 32'h0F, 32'h0F};
      logic [31:0] t_c  [6] = '{32'd3, 32'd3, 32'hFF, 32'h0, 32'h30, 32'h30};
      logic [31:0] t_d  [6] = '{32'd2, 32'd2, 32'hFF, 32'h1, 32'h0, 32'h0};
      logic [63:0] t_y  [6] = '{64'd6, 64'hFFFFFFFF_FFFFFFFC, 64'hFFFFFF80_FFFFFFFE,
                                64'h00000001_00000000, 64'h00000000_000000C0, 64'd0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(t_op[i], t_fl[i], t_fm[i], t_p[i], t_a[i], t_b[i], t_c[i], t_d[i]);
         @(posedge clk);
         #1;
         total++;
         if ({Y1, Y2} !== t_y[i]) begin
            bad++;
            $display("FAIL directed[%0d] got=%h want=%h", i, {Y1, Y2}, t_y[i]);
         end
      end
   endtask

   task automatic test_stable_between_edges();
      logic [63:0] exp_old, exp_new;
      @(negedge clk);
      drive(3'd3, 1'b0, 1'b0, 2'd1, 32'h1234_8001, 32'h0000_7FFF, 32'hAAAA_5555, 32'h0F0F_F0F0);
      exp_old = model(3'd3, 1'b0, 1'b0, 2'd1, 32'h1234_8001, 32'h0000_7FFF, 32'hAAAA_5555, 32'h0F0F_F0F0);
      @(posedge clk);
      #2;
      drive(3'd0, 1'b0, 1'b1, 2'd0, 32'h80, 32'h80, 32'h7F, 32'h0);
      exp_new = model(3'd0, 1'b0, 1'b1, 2'd0, 32'h80, 32'h80, 32'h7F, 32'h0);
      #1;
      total++;
      if ({Y1, Y2} !== exp_old) begin
         bad++;
         $display("FAIL stable_mid_cycle got=%h want=%h", {Y1, Y2}, exp_old);
      end
      @(posedge clk);
      #1;
      total++;
      if ({Y1, Y2} !== exp_new) begin
         bad++;
         $display("FAIL stable_next_edge got=%h want=%h", {Y1, Y2}, exp_new);
      end
   endtask

   task automatic test_async_reset();
      logic [63:0] exp;
      @(negedge clk);
      drive(3'd0, 1'b0, 1'b1, 2'd2, 32'd5, 32'd6, 32'd7, 32'd0);
      @(posedge clk);
      #1;
      total++;
      if ({Y1, Y2} !== 64'd18) begin
         bad++;
         $display("FAIL async_pre got=%h want=%h", {Y1, Y2}, 64'd18);
      end
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if ({Y1, Y2} !== 64'd0) begin
         bad++;
         $display("FAIL async_immediate got=%h want=%h", {Y1, Y2}, 64'd0);
      end
      @(posedge clk);
      #1;
      total++;
      if ({Y1, Y2} !== 64'd0) begin
         bad++;
         $display("FAIL async_edge_ignored got=%h want=%h", {Y1, Y2}, 64'd0);
      end
      @(negedge clk);
      drive(3'd4, 1'b0, 1'b0, 2'd3, 32'd0, 32'd0, 32'd0, 32'd1);
      rst_n = 1'b1;
      #1;
      total++;
      if ({Y1, Y2} !== 64'd0) begin
         bad++;
         $display("FAIL async_released_held got=%h want=%h", {Y1, Y2}, 64'd0);
      end
      exp = 64'hFFFFFFFF_FFFFFFFF;
      @(posedge clk);
      #1;
      total++;
      if ({Y1, Y2} !== exp) begin
         bad++;
         $display("FAIL async_first_edge got=%h want=%h", {Y1, Y2}, exp);
      end
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic        fl, fm;
      logic [1:0]  p;
      logic [31:0] a, b, c, d;
      logic [63:0] exp;
      for (int i = 0; i < 400; i++) begin
         o  = 3'($urandom_range(0, 7));
         fl = ($urandom_range(0, 7) == 0);
         fm = 1'($urandom_range(0, 1));
         p  = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         c  = $urandom;
         d  = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'h0000_007F;
         if ($urandom_range(0, 3) == 0) b = 32'hFFFF_FFFF;
         @(negedge clk);
         drive(o, fl, fm, p, a, b, c, d);
         exp = model(o, fl, fm, p, a, b, c, d);
         @(posedge clk);
         #1;
         total++;
         if ({Y1, Y2} !== exp) begin
            bad++;
            $display("FAIL random[%0d] op=%0d fl=%0d form=%0d prec=%0d got=%h want=%h",
                     i, o, fl, fm, p, {Y1, Y2}, exp);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_directed();
      test_stable_between_edges();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
